// File: rtl/ov5640_power_seq.sv
// OV5640 power-up sequencer: PWDN hold, RESETB hold, boot wait, SCCB config, frame skip, then capture gating.
// Latency: outputs registered with state; sw_1/vsync pass a 2-flop sync (+1 edge-detect stage for vsync).
// Backpressure: none; synced sw_1=0 forces OFF next clock from any state, cfg timeout parks in FAULT until sw_1 drops.
module ov5640_power_seq #(
    parameter int unsigned CNT_PWDN    = 150000,
    parameter int unsigned CNT_RST     = 50000,
    parameter int unsigned CNT_BOOT    = 525000,
    parameter int unsigned CFG_TIMEOUT = 25000000,
    parameter int unsigned FRAME_SKIP  = 10
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       sw_1,
    input  logic       sdram_init_done,
    input  logic       cfg_done,
    input  logic       ov5640_vsync,
    output logic       ov5640_pwdn,
    output logic       ov5640_rst_n,
    output logic       cfg_start,
    output logic       capture_en,
    output logic       sys_init_done,
    output logic       cfg_fault,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_PWDN  = 3'd1,
        S_RST   = 3'd2,
        S_BOOT  = 3'd3,
        S_CFG   = 3'd4,
        S_SKIP  = 3'd5,
        S_RUN   = 3'd6,
        S_FAULT = 3'd7
    } state_t;

    // Counter reload values: a state lasting N clocks starts at N-1 and exits on 0.
    localparam logic [24:0] LD_PWDN = 25'(CNT_PWDN - 1);
    localparam logic [24:0] LD_RST  = 25'(CNT_RST - 1);
    localparam logic [24:0] LD_BOOT = 25'(CNT_BOOT - 1);
    localparam logic [24:0] LD_CFG  = 25'(CFG_TIMEOUT - 1);
    localparam logic [7:0]  FS_LAST = 8'(FRAME_SKIP - 1);
    localparam bit          FS_NONE = (FRAME_SKIP == 0);

    state_t      state, nxt;
    logic [24:0] cnt, cnt_nxt;
    logic [7:0]  fcnt, fcnt_nxt;
    logic        sw_meta, sw_sync;
    logic        vs_meta, vs_sync, vs_prev;
    logic        vs_rise;
    logic        entering;
    logic        pwdn_nxt, rst_n_nxt, cfg_start_nxt, capture_nxt, init_nxt, fault_nxt;

    assign vs_rise   = vs_sync & ~vs_prev;
    assign seq_state = state;

    // Two-flop synchronisers for the switch and the pclk-domain vsync, plus vsync history for edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sw_meta <= 1'b0;
            sw_sync <= 1'b0;
            vs_meta <= 1'b0;
            vs_sync <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            sw_meta <= sw_1;
            sw_sync <= sw_meta;
            vs_meta <= ov5640_vsync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    // Next state, counter updates and next output values; outputs are derived from the next state so they align with it.
    always_comb begin
        nxt           = state;
        cnt_nxt       = cnt;
        fcnt_nxt      = fcnt;
        fault_nxt     = cfg_fault;
        entering      = 1'b0;
        pwdn_nxt      = 1'b1;
        rst_n_nxt     = 1'b0;
        cfg_start_nxt = 1'b0;
        capture_nxt   = 1'b0;
        init_nxt      = 1'b0;

        case (state)
            S_OFF:   if (sw_sync) nxt = S_PWDN;
            S_PWDN:  if (cnt == '0) nxt = S_RST;
            S_RST:   if (cnt == '0) nxt = S_BOOT;
            S_BOOT:  if (cnt == '0) nxt = S_CFG;
            // cfg_done takes priority over the timeout expiring in the same cycle.
            S_CFG:   if (cfg_done) nxt = S_SKIP;
                     else if (cnt == '0) nxt = S_FAULT;
            S_SKIP:  if (FS_NONE || (vs_rise && fcnt == FS_LAST)) nxt = S_RUN;
            S_RUN:   nxt = S_RUN;
            S_FAULT: nxt = S_FAULT;
            default: nxt = S_OFF;
        endcase

        // Power request withdrawn: everything collapses to OFF, which also drops a pending cfg_start.
        if (!sw_sync) nxt = S_OFF;

        entering = (nxt != state);

        if (entering) begin
            case (nxt)
                S_PWDN:  cnt_nxt = LD_PWDN;
                S_RST:   cnt_nxt = LD_RST;
                S_BOOT:  cnt_nxt = LD_BOOT;
                S_CFG:   cnt_nxt = LD_CFG;
                default: cnt_nxt = '0;
            endcase
        end else if (cnt != '0) begin
            cnt_nxt = cnt - 25'd1;
        end

        if (entering && nxt == S_SKIP) fcnt_nxt = '0;
        else if (state == S_SKIP && vs_rise) fcnt_nxt = fcnt + 8'd1;

        if (entering && nxt == S_PWDN) fault_nxt = 1'b0;
        else if (entering && nxt == S_FAULT) fault_nxt = 1'b1;

        pwdn_nxt      = (nxt == S_OFF) || (nxt == S_PWDN);
        rst_n_nxt     = !((nxt == S_OFF) || (nxt == S_PWDN) || (nxt == S_RST));
        cfg_start_nxt = entering && (nxt == S_CFG);
        // Capture opens only on a frame boundary inside RUN and then holds until RUN is left.
        capture_nxt   = (nxt == S_RUN) && (capture_en || (state == S_RUN && vs_rise));
        init_nxt      = capture_nxt && sdram_init_done;
    end

    // State, counters and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= S_OFF;
            cnt           <= '0;
            fcnt          <= '0;
            ov5640_pwdn   <= 1'b1;
            ov5640_rst_n  <= 1'b0;
            cfg_start     <= 1'b0;
            capture_en    <= 1'b0;
            sys_init_done <= 1'b0;
            cfg_fault     <= 1'b0;
        end else begin
            state         <= nxt;
            cnt           <= cnt_nxt;
            fcnt          <= fcnt_nxt;
            ov5640_pwdn   <= pwdn_nxt;
            ov5640_rst_n  <= rst_n_nxt;
            cfg_start     <= cfg_start_nxt;
            capture_en    <= capture_nxt;
            sys_init_done <= init_nxt;
            cfg_fault     <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_ov5640_power_seq.sv
// Testbench for ov5640_power_seq: randomized power-up, timeout, simultaneous-event, power-off, reset and gating scenarios.
// Timing model works in sample ticks (one per clock, taken at the falling edge) using the documented phase lengths.
// Inputs change right after each sample, so they are seen at the following rising edge.
module tb_ov5640_power_seq;

    localparam int CNT_PWDN    = 6;
    localparam int CNT_RST     = 4;
    localparam int CNT_BOOT    = 8;
    localparam int CFG_TIMEOUT = 20;
    localparam int FRAME_SKIP  = 2;
    // Two synchroniser flops plus the clock on which the FSM reacts.
    localparam int SYNC_LAT    = 3;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n, sw_1, sdram_init_done, cfg_done, ov5640_vsync;
    logic       ov5640_pwdn, ov5640_rst_n, cfg_start, capture_en, sys_init_done, cfg_fault;
    logic [2:0] seq_state;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int vs_period   = 30;
    int vs_phase    = 0;
    int rise_q[$];

    ov5640_power_seq #(
        .CNT_PWDN    (CNT_PWDN),
        .CNT_RST     (CNT_RST),
        .CNT_BOOT    (CNT_BOOT),
        .CFG_TIMEOUT (CFG_TIMEOUT),
        .FRAME_SKIP  (FRAME_SKIP)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .sw_1            (sw_1),
        .sdram_init_done (sdram_init_done),
        .cfg_done        (cfg_done),
        .ov5640_vsync    (ov5640_vsync),
        .ov5640_pwdn     (ov5640_pwdn),
        .ov5640_rst_n    (ov5640_rst_n),
        .cfg_start       (cfg_start),
        .capture_en      (capture_en),
        .sys_init_done   (sys_init_done),
        .cfg_fault       (cfg_fault),
        .seq_state       (seq_state)
    );

    always #5 sys_clk = ~sys_clk;

    // Advance one clock, land on the falling edge, then drive the free-running vsync pattern.
    task automatic tick();
        logic v;
        @(posedge sys_clk);
        @(negedge sys_clk);
        cyc++;
        v = (((cyc + vs_phase) % vs_period) < 3);
        if (v && !ov5640_vsync) rise_q.push_back(cyc);
        ov5640_vsync = v;
    endtask

    // Reference: tick at which the n-th synced vsync rising edge acts while the FSM is already in SKIP/RUN.
    function automatic int model_edge(input int t_skip, input int n);
        int k;
        k = 0;
        foreach (rise_q[i]) begin
            if (rise_q[i] + SYNC_LAT > t_skip) begin
                k++;
                if (k == n) return rise_q[i] + SYNC_LAT;
            end
        end
        return -1;
    endfunction

    // Walk from a power request to the cfg_start pulse, recording phase boundaries (no checking here).
    task automatic trace_to_cfg(output int t_pw, output int t_rst, output int t_boot, output int t_cs,
                                output logic f_pw);
        t_pw = -1; t_rst = -1; t_boot = -1; t_cs = -1; f_pw = 1'bx;
        for (int i = 0; i < 200 && t_cs < 0; i++) begin
            tick();
            if (t_pw < 0 && seq_state == 3'd1) begin
                t_pw = cyc;
                f_pw = cfg_fault;
            end
            if (t_pw >= 0 && t_rst < 0 && !ov5640_pwdn) t_rst = cyc;
            if (t_rst >= 0 && t_boot < 0 && ov5640_rst_n) t_boot = cyc;
            if (cfg_start) t_cs = cyc;
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0; sw_1 = 1'b0; sdram_init_done = 1'b0; cfg_done = 1'b0; ov5640_vsync = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({seq_state, ov5640_pwdn, ov5640_rst_n, cfg_start, capture_en, sys_init_done, cfg_fault} !== 9'b000100000) begin
            miscompares++;
            $display("FAIL reset_values: got %b expected %b",
                     {seq_state, ov5640_pwdn, ov5640_rst_n, cfg_start, capture_en, sys_init_done, cfg_fault}, 9'b000100000);
        end
        sys_rst_n = 1'b1;
        repeat (5) tick();
        vectors++;
        if (seq_state !== 3'd0 || ov5640_pwdn !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_off: got state %0d pwdn %b expected state 0 pwdn 1", seq_state, ov5640_pwdn);
        end
    endtask

    // Full power-up to capture; leaves the DUT in RUN with capture_en set.
    task automatic test_power_up(input int d, input logic sdram_lvl);
        int t0, t_pw, t_rst, t_boot, t_cs, t_skip, t_run, t_cap, e_skip, e_run, e_cap;
        logic f_pw, init_at_cap;
        rise_q.delete();
        cfg_done = 1'b0;
        sdram_init_done = sdram_lvl;
        sw_1 = 1'b1;
        t0 = cyc;
        trace_to_cfg(t_pw, t_rst, t_boot, t_cs, f_pw);
        vectors++;
        if (t_pw - t0 !== SYNC_LAT) begin
            miscompares++; $display("FAIL pwdn_entry: got %0d expected %0d", t_pw - t0, SYNC_LAT);
        end
        vectors++;
        if (t_rst - t_pw !== CNT_PWDN) begin
            miscompares++; $display("FAIL pwdn_hold: got %0d expected %0d", t_rst - t_pw, CNT_PWDN);
        end
        vectors++;
        if (t_boot - t_rst !== CNT_RST) begin
            miscompares++; $display("FAIL rst_hold: got %0d expected %0d", t_boot - t_rst, CNT_RST);
        end
        vectors++;
        if (t_cs - t_boot !== CNT_BOOT) begin
            miscompares++; $display("FAIL boot_wait: got %0d expected %0d", t_cs - t_boot, CNT_BOOT);
        end
        t_skip = -1; t_run = -1; t_cap = -1; init_at_cap = 1'bx;
        for (int i = 0; i < 400 && t_cap < 0; i++) begin
            if (cyc == t_cs + d) cfg_done = 1'b1;
            tick();
            if (cyc == t_cs + 1) begin
                vectors++;
                if (cfg_start !== 1'b0) begin
                    miscompares++; $display("FAIL cfg_start_width: got %b expected 0", cfg_start);
                end
            end
            if (t_skip < 0 && seq_state == 3'd5) t_skip = cyc;
            if (t_run < 0 && seq_state == 3'd6) t_run = cyc;
            if (capture_en === 1'b1) begin
                t_cap = cyc;
                init_at_cap = sys_init_done;
            end
        end
        e_skip = t_cs + d + 1;
        e_run  = model_edge(e_skip, FRAME_SKIP);
        e_cap  = model_edge(e_skip, FRAME_SKIP + 1);
        vectors++;
        if (t_skip !== e_skip) begin
            miscompares++; $display("FAIL skip_entry: got %0d expected %0d (d=%0d)", t_skip, e_skip, d);
        end
        vectors++;
        if (t_run !== e_run) begin
            miscompares++; $display("FAIL run_entry: got %0d expected %0d", t_run, e_run);
        end
        vectors++;
        if (t_cap !== e_cap) begin
            miscompares++; $display("FAIL capture_start: got %0d expected %0d", t_cap, e_cap);
        end
        vectors++;
        if (init_at_cap !== sdram_lvl) begin
            miscompares++; $display("FAIL init_at_capture: got %b expected %b", init_at_cap, sdram_lvl);
        end
    endtask

    task automatic test_power_off();
        sw_1 = 1'b0;
        repeat (2) tick();
        vectors++;
        if (seq_state === 3'd0) begin
            miscompares++; $display("FAIL off_too_early: got state %0d expected nonzero", seq_state);
        end
        tick();
        vectors++;
        if ({seq_state, ov5640_pwdn, ov5640_rst_n, capture_en, sys_init_done} !== 7'b0001000) begin
            miscompares++;
            $display("FAIL power_off: got %b expected %b",
                     {seq_state, ov5640_pwdn, ov5640_rst_n, capture_en, sys_init_done}, 7'b0001000);
        end
        cfg_done = 1'b0;
        repeat ($urandom_range(2, 6)) tick();
    endtask

    task automatic test_init_gating();
        int t;
        repeat ($urandom_range(1, 10)) tick();
        vectors++;
        if (capture_en !== 1'b1 || sys_init_done !== 1'b0) begin
            miscompares++; $display("FAIL init_gated: got cap %b init %b expected cap 1 init 0", capture_en, sys_init_done);
        end
        sdram_init_done = 1'b1;
        t = cyc;
        tick();
        vectors++;
        if (sys_init_done !== 1'b1 || cyc - t !== 1) begin
            miscompares++; $display("FAIL init_rise: got %b expected 1", sys_init_done);
        end
    endtask

    task automatic test_timeout();
        int t0, t_pw, t_rst, t_boot, t_cs;
        logic f_pw;
        cfg_done = 1'b0;
        sw_1 = 1'b1;
        t0 = cyc;
        trace_to_cfg(t_pw, t_rst, t_boot, t_cs, f_pw);
        vectors++;
        if (t_cs - t0 !== SYNC_LAT + CNT_PWDN + CNT_RST + CNT_BOOT) begin
            miscompares++; $display("FAIL to_cfg_start: got %0d expected %0d", t_cs - t0, SYNC_LAT + CNT_PWDN + CNT_RST + CNT_BOOT);
        end
        while (t_cs >= 0 && cyc < t_cs + CFG_TIMEOUT - 1) tick();
        vectors++;
        if (seq_state !== 3'd4 || cfg_fault !== 1'b0) begin
            miscompares++; $display("FAIL pre_timeout: got state %0d fault %b expected state 4 fault 0", seq_state, cfg_fault);
        end
        tick();
        vectors++;
        if (seq_state !== 3'd7 || cfg_fault !== 1'b1 || ov5640_pwdn !== 1'b0 || ov5640_rst_n !== 1'b1) begin
            miscompares++; $display("FAIL timeout: got state %0d fault %b expected state 7 fault 1", seq_state, cfg_fault);
        end
        repeat ($urandom_range(2, 10)) tick();
        vectors++;
        if (seq_state !== 3'd7) begin
            miscompares++; $display("FAIL fault_hold: got state %0d expected 7", seq_state);
        end
        sw_1 = 1'b0;
        repeat (SYNC_LAT) tick();
        vectors++;
        if (seq_state !== 3'd0 || ov5640_pwdn !== 1'b1 || cfg_fault !== 1'b1) begin
            miscompares++;
            $display("FAIL fault_exit: got state %0d pwdn %b fault %b expected state 0 pwdn 1 fault 1", seq_state, ov5640_pwdn, cfg_fault);
        end
        repeat (3) tick();
    endtask

    task automatic test_simultaneous();
        int t0, t_pw, t_rst, t_boot, t_cs;
        logic f_pw;
        cfg_done = 1'b0;
        sw_1 = 1'b1;
        t0 = cyc;
        trace_to_cfg(t_pw, t_rst, t_boot, t_cs, f_pw);
        vectors++;
        if (f_pw !== 1'b0) begin
            miscompares++; $display("FAIL fault_clear_pwdn: got %b expected 0", f_pw);
        end
        while (t_cs >= 0 && cyc < t_cs + CFG_TIMEOUT - 1) tick();
        cfg_done = 1'b1;
        tick();
        vectors++;
        if (seq_state !== 3'd5 || cfg_fault !== 1'b0) begin
            miscompares++; $display("FAIL simultaneous: got state %0d fault %b expected state 5 fault 0", seq_state, cfg_fault);
        end
    endtask

    task automatic test_reset_mid_boot();
        int t0, t_pw, t_rst, t_boot, t_cs;
        logic f_pw;
        cfg_done = 1'b0;
        sw_1 = 1'b1;
        for (int i = 0; i < 100 && seq_state != 3'd3; i++) tick();
        repeat ($urandom_range(0, 5)) tick();
        #2 sys_rst_n = 1'b0;
        #1;
        vectors++;
        if ({seq_state, ov5640_pwdn, ov5640_rst_n, cfg_start, capture_en, sys_init_done, cfg_fault} !== 9'b000100000) begin
            miscompares++;
            $display("FAIL async_reset: got %b expected %b",
                     {seq_state, ov5640_pwdn, ov5640_rst_n, cfg_start, capture_en, sys_init_done, cfg_fault}, 9'b000100000);
        end
        repeat (2) tick();
        sys_rst_n = 1'b1;
        t0 = cyc;
        trace_to_cfg(t_pw, t_rst, t_boot, t_cs, f_pw);
        vectors++;
        if (t_pw - t0 !== SYNC_LAT || t_rst - t_pw !== CNT_PWDN || t_boot - t_rst !== CNT_RST || t_cs - t_boot !== CNT_BOOT) begin
            miscompares++;
            $display("FAIL restart_timing: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                     t_pw - t0, t_rst - t_pw, t_boot - t_rst, t_cs - t_boot, SYNC_LAT, CNT_PWDN, CNT_RST, CNT_BOOT);
        end
    endtask

    initial begin
        test_reset();
        vs_period = 30;
        vs_phase  = int'($urandom_range(0, 29));
        test_power_up(5, 1'b1);
        test_power_off();
        for (int it = 0; it < 3; it++) begin
            vs_period = int'($urandom_range(20, 40));
            vs_phase  = int'($urandom_range(0, 39));
            test_power_up(int'($urandom_range(0, 18)), 1'b1);
            test_power_off();
        end
        test_power_up(int'($urandom_range(0, 18)), 1'b0);
        test_init_gating();
        test_power_off();
        test_timeout();
        test_simultaneous();
        test_power_off();
        test_reset_mid_boot();
        test_power_off();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ov5640_power_seq.md
OV5640_POWER_SEQ -- requirements
Module: ov5640_power_seq

Interface
REQ-001 The block SHALL have parameter CNT_PWDN, default 150000, giving the PWDN-high hold in clocks (6 ms at 25 MHz).
REQ-002 The block SHALL have parameter CNT_RST, default 50000, giving the RESETB-low hold in clocks (2 ms).
REQ-003 The block SHALL have parameter CNT_BOOT, default 525000, giving the wait from reset release to the first SCCB access in clocks (21 ms).
REQ-004 The block SHALL have parameter CFG_TIMEOUT, default 25000000, giving the maximum clocks from cfg_start to cfg_done (1 s).
REQ-005 The block SHALL have parameter FRAME_SKIP, default 10, giving the number of complete frames discarded after configuration.
REQ-006 sys_clk  in  1  single block clock (clk_25m domain); all logic is clocked on its rising edge.
REQ-007 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-008 sw_1  in  1  camera power request, asynchronous; 1 = on.
REQ-009 sdram_init_done  in  1  SDRAM initialisation complete, level, sys_clk domain.
REQ-010 cfg_done  in  1  SCCB register configuration complete, level, sys_clk domain.
REQ-011 ov5640_vsync  in  1  camera frame sync, pclk domain, active high.
REQ-012 ov5640_pwdn  out  1  camera power-down; 1 = powered down.
REQ-013 ov5640_rst_n  out  1  camera reset, active low.
REQ-014 cfg_start  out  1  one-cycle pulse that starts the SCCB configuration.
REQ-015 capture_en  out  1  gates ov5640_wr_en into the SDRAM write FIFO.
REQ-016 sys_init_done  out  1  asserted while capture_en=1 and sdram_init_done=1.
REQ-017 cfg_fault  out  1  sticky configuration timeout flag.
REQ-018 seq_state  out  3  current FSM state encoding.

Function
REQ-019 sw_1 and ov5640_vsync SHALL each pass through a two-flop synchroniser before use.
REQ-020 The FSM SHALL use these states and encodings: OFF=0, PWDN=1, RST=2, BOOT=3, CFG=4, SKIP=5, RUN=6, FAULT=7.
REQ-021 Outputs per state SHALL be as follows.
- OFF and PWDN: pwdn=1, rst_n=0.
- RST: pwdn=0, rst_n=0.
- BOOT, CFG, SKIP, RUN and FAULT: pwdn=0, rst_n=1.
REQ-022 In OFF, the FSM SHALL go to PWDN when synced sw_1=1.
REQ-023 In PWDN, the FSM SHALL go to RST after exactly CNT_PWDN clocks in PWDN.
REQ-024 In RST, the FSM SHALL go to BOOT after exactly CNT_RST clocks.
REQ-025 In BOOT, the FSM SHALL go to CFG after exactly CNT_BOOT clocks.
REQ-026 cfg_start SHALL pulse high for exactly one clock, on the first cycle in CFG.
REQ-027 In CFG, the FSM SHALL behave as follows.
- cfg_done=1 -> SKIP.
- CFG_TIMEOUT clocks elapse without cfg_done -> FAULT, and cfg_fault is set.
- If cfg_done=1 on the timeout cycle, cfg_done wins.
REQ-028 In SKIP, a frame SHALL be counted on each rising edge of synced vsync; after FRAME_SKIP edges the FSM SHALL go to RUN.
REQ-029 In RUN, capture_en SHALL be set only on a synced-vsync rising edge, so capture starts at a frame boundary; it stays 1 until RUN is left.
REQ-030 FAULT SHALL hold until synced sw_1=0.
REQ-031 In any state except OFF, synced sw_1=0 SHALL force a transition to OFF on the next clock, with the following effects.
- capture_en clears in the same cycle.
- A pending cfg_start is not issued.
REQ-032 cfg_fault SHALL clear only on reset or on re-entry to PWDN.
REQ-033 A single 25-bit down-counter SHALL be shared by all states.
- It is loaded with (duration−1) on state entry.
- A state exits when the counter reads 0.
- It does not wrap.
REQ-034 The frame counter SHALL be 8 bits wide and reset on SKIP entry.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 While sys_rst_n=0, the block SHALL hold the following values.
- State OFF, ov5640_pwdn=1, ov5640_rst_n=0.
- cfg_start=0, capture_en=0, sys_init_done=0, cfg_fault=0.
- Counters 0, synchronisers 0.
REQ-037 Reset assertion mid-sequence SHALL take effect immediately (asynchronously).
REQ-038 After release, the sequence SHALL restart from OFF.

Verification (CNT_PWDN=6, CNT_RST=4, CNT_BOOT=8, CFG_TIMEOUT=20, FRAME_SKIP=2)
REQ-039 Bench: power-up. sw_1=1, cfg_done raised 5 clocks after cfg_start, vsync period 30 clocks.
- Required response: pwdn high for 6 clocks, then rst_n low for 4 clocks, then cfg_start 8 clocks after rst_n rises.
- capture_en rises on the 3rd vsync edge after cfg_done.
REQ-040 Bench: timeout. cfg_done held 0.
- Required response: cfg_fault=1 and seq_state=7 twenty clocks after cfg_start.
- Dropping sw_1 then returns to OFF (pwdn=1).
REQ-041 Bench: simultaneous events. cfg_done asserted on the timeout cycle.
- Required response: SKIP entered and cfg_fault stays 0.
REQ-042 Bench: power-off. sw_1 dropped in RUN.
- Required response: within 3 clocks (2 sync + 1) capture_en=0, pwdn=1, rst_n=0.
REQ-043 Bench: reset. sys_rst_n pulsed low during BOOT.
- Required response: outputs immediately take reset values.
- After release with sw_1=1, the full PWDN/RST/BOOT timing repeats.
REQ-044 Bench: sys_init_done gating. sdram_init_done=0 while in RUN.
- Required response: sys_init_done=0 while capture_en=1.
- sys_init_done rises 1 clock after sdram_init_done rises.
